// File: rtl/param_sync_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Package : fifo_pkg
// Shared defaults and sizing helper for the param_sync_fifo slice.
// Rev     : 1.0  initial release
// ============================================================================
package fifo_pkg;

    localparam int DEF_DATA_W = 128;
    localparam int DEF_DEPTH  = 16;

    // One extra bit so that a completely full FIFO (count == depth) fits.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/param_sync_fifo_if.sv
`default_nettype none
// ============================================================================
// Interface : f_interface
// FIFO handshake bundle; error flags exist only with PARAM_SYNC_FIFO_ERR_EN.
// Rev       : 1.0  initial release
// ============================================================================
interface f_interface
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = cnt_w(DEF_DEPTH)
);
    logic              i_wren;
    logic              i_rden;
    logic [DATA_W-1:0] i_wrdata;
    logic [DATA_W-1:0] o_rddata;
    logic              o_full;
    logic              o_empty;
    logic              o_alm_full;
    logic              o_alm_empty;
    logic [CNT_W-1:0]  o_count;
`ifdef PARAM_SYNC_FIFO_ERR_EN
    logic              o_overflow;
    logic              o_underflow;

    modport master (
        output i_wren, i_rden, i_wrdata,
        input  o_rddata, o_full, o_empty, o_alm_full, o_alm_empty, o_count,
        input  o_overflow, o_underflow
    );
    modport slave (
        input  i_wren, i_rden, i_wrdata,
        output o_rddata, o_full, o_empty, o_alm_full, o_alm_empty, o_count,
        output o_overflow, o_underflow
    );
`else
    modport master (
        output i_wren, i_rden, i_wrdata,
        input  o_rddata, o_full, o_empty, o_alm_full, o_alm_empty, o_count
    );
    modport slave (
        input  i_wren, i_rden, i_wrdata,
        output o_rddata, o_full, o_empty, o_alm_full, o_alm_empty, o_count
    );
`endif

endinterface : f_interface
`default_nettype wire

// File: rtl/param_sync_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module : fifo_mem
// Simple dual-port array: synchronous write, registered read with enable.
// Rev    : 1.0  initial release
// ============================================================================
module fifo_mem #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_waddr,
    input  wire logic [DATA_W-1:0] i_wdata,
    input  wire logic              i_re,
    input  wire logic [ADDR_W-1:0] i_raddr,
    output logic      [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage array is deliberately not reset; only the output register is.
    always_ff @(posedge clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (i_re) begin
            rdata_q <= mem_q[i_raddr];
        end
    end

    assign o_rdata = rdata_q;

endmodule : fifo_mem
`default_nettype wire

// File: rtl/param_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module : param_sync_fifo
// Parametrised single-clock FIFO with registered flags and occupancy count.
// Optional sticky overflow/underflow flags: define PARAM_SYNC_FIFO_ERR_EN.
// Rev    : 1.0  initial release
// ============================================================================
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input wire logic  clk,
    input wire logic  rst,
    f_interface.slave bus
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_CNT_W  = cnt_w(DEPTH);

    logic [c_ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0]  count_q, count_d;
    logic                full_q, empty_q, alm_full_q, alm_empty_q;
    logic                w_wr_acc, w_rd_acc;

    // Acceptance looks only at the registered flags: no same-cycle bypass.
    assign w_wr_acc = bus.i_wren & ~full_q;
    assign w_rd_acc = bus.i_rden & ~empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + {{(c_CNT_W-1){1'b0}}, w_wr_acc}
                          - {{(c_CNT_W-1){1'b0}}, w_rd_acc};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            alm_full_q  <= 1'b0;
            alm_empty_q <= 1'b1;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= (count_d == c_CNT_W'(DEPTH));
            empty_q     <= (count_d == '0);
            alm_full_q  <= (count_d >= c_CNT_W'(AF_THRESH));
            alm_empty_q <= (count_d <= c_CNT_W'(AE_THRESH));
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (c_ADDR_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_wr_acc),
        .i_waddr (wr_ptr_q),
        .i_wdata (bus.i_wrdata),
        .i_re    (w_rd_acc),
        .i_raddr (rd_ptr_q),
        .o_rdata (bus.o_rddata)
    );

    assign bus.o_full      = full_q;
    assign bus.o_empty     = empty_q;
    assign bus.o_alm_full  = alm_full_q;
    assign bus.o_alm_empty = alm_empty_q;
    assign bus.o_count     = count_q;

`ifdef PARAM_SYNC_FIFO_ERR_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    // A read against an empty FIFO is flagged even if a write lands that cycle.
    always_comb begin
        ovf_d = ovf_q | (bus.i_wren & full_q);
        unf_d = unf_q | (bus.i_rden & empty_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign bus.o_overflow  = ovf_q;
    assign bus.o_underflow = unf_q;
`endif

endmodule : param_sync_fifo
`default_nettype wire
